imem_loader: RTL and testbench

//   Boot loader and memory writer for the core's instruction/data BRAM. It takes a

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to 32-bit BRAM word writer.
// Holds the core in reset until a load ends with a good checksum.
module imem_loader #(
  parameter int unsigned        ADDR_W    = 13,
  parameter logic [7:0]         MAGIC     = 8'hA5,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0] MAX_N = 17'(1) << (ADDR_W - 2);

  state_t      state;
  state_t      next;
  logic [15:0] len;
  logic [23:0] word;
  logic [1:0]  byte_idx;
  logic [7:0]  checksum;

  logic        xfer;
  logic        is_magic;
  logic [16:0] n_full;
  logic        n_too_big;
  logic        n_zero;
  logic        last_byte;
  logic        last_word;

  assign rx_ready  = 1'b1;
  assign xfer      = rx_valid & rx_ready;
  assign is_magic  = (rx_data == MAGIC);
  assign n_full    = {1'b0, rx_data, len[7:0]};
  assign n_too_big = (n_full > MAX_N);
  assign n_zero    = (n_full == 17'd0);
  assign last_byte = (byte_idx == 2'd3);
  assign last_word = ((17'(words_loaded) + 17'd1) == {1'b0, len});

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next;
  end

  // Next-state decode; moves only on a byte transfer
  always_comb begin
    next = state;
    if (xfer) begin
      unique case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (is_magic) next = S_LEN_LO;
        end
        S_LEN_LO: next = S_LEN_HI;
        S_LEN_HI: begin
          if (n_too_big)   next = S_ERR;
          else if (n_zero) next = S_CHK;
          else             next = S_DATA;
        end
        S_DATA: begin
          if (last_byte && last_word) next = S_CHK;
        end
        S_CHK: next = (rx_data == checksum) ? S_DONE : S_ERR;
        default: next = S_IDLE;
      endcase
    end
  end

  // Datapath: length, word packing, checksum, write pulse, status
  always_ff @(posedge clk) begin
    if (rst) begin
      len          <= '0;
      word         <= '0;
      byte_idx     <= '0;
      checksum     <= '0;
      mem_we       <= '0;
      mem_addr     <= BASE_ADDR;
      mem_din      <= '0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
      words_loaded <= '0;
    end else begin
      mem_we <= 4'h0;
      if (xfer) begin
        unique case (state)
          S_IDLE, S_DONE, S_ERR: begin
            if (is_magic) begin
              core_hold    <= 1'b1;
              done         <= 1'b0;
              err          <= 1'b0;
              words_loaded <= '0;
              checksum     <= '0;
            end
          end
          S_LEN_LO: len[7:0] <= rx_data;
          S_LEN_HI: begin
            len[15:8] <= rx_data;
            byte_idx  <= '0;
            if (n_too_big) err <= 1'b1;
          end
          S_DATA: begin
            checksum <= checksum ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (last_byte) begin
              mem_we       <= 4'hF;
              mem_addr     <= BASE_ADDR
                            + {words_loaded[ADDR_W-3:0], 2'b00};
              mem_din      <= {rx_data, word};
              words_loaded <= words_loaded + 1'b1;
            end else begin
              word[{byte_idx, 3'b000} +: 8] <= rx_data;
            end
          end
          S_CHK: begin
            if (rx_data == checksum) begin
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed frames with a write scoreboard.
// Expected BRAM writes are queued as bytes are driven.
module tb_imem_loader;

  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_valid;
  logic [7:0]    rx_data;
  logic          rx_ready;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          core_hold;
  logic          done;
  logic          err;
  logic [AW-1:0] words_loaded;

  int checks = 0;
  int errors = 0;
  int drops  = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
  } wr_t;

  wr_t exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W   (AW),
    .MAGIC    (8'hA5),
    .BASE_ADDR('0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_din     (mem_din),
    .core_hold   (core_hold),
    .done        (done),
    .err         (err),
    .words_loaded(words_loaded)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we !== 4'h0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_write: observed addr %h din %h expected none",
               mem_addr, mem_din);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_we", 32'(mem_we), 32'hF);
        chk("wr_addr", 32'(mem_addr), e.addr);
        chk("wr_din", mem_din, e.din);
      end
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.din  = d;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    if (rx_ready !== 1'b1) drops++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic status(input string tag, input logic d,
                        input logic e, input logic h,
                        input logic [31:0] w);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_hold"}, 32'(core_hold), 32'(h));
    chk({tag, "_words"}, 32'(words_loaded), w);
  endtask

  task automatic frame_one();
    push(32'h0, 32'h0000_0013);
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h13);
  endtask

  task automatic frame_two(input logic [7:0] ck);
    push(32'h0, 32'h1413_1211);
    push(32'h4, 32'h1817_1615);
    send(8'hA5); send(8'h02); send(8'h00);
    for (int i = 0; i < 8; i++) send(8'(8'h11 + i));
    send(ck);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    status("reset", 1'b0, 1'b0, 1'b1, 0);
    chk("reset_ready", 32'(rx_ready), 32'h1);
    chk("reset_we", 32'(mem_we), 32'h0);
    chk("reset_addr", 32'(mem_addr), 32'h0);
    chk("reset_din", mem_din, 32'h0);

    // Single-word load
    frame_one();
    status("t1", 1'b1, 1'b0, 1'b0, 1);
    idle(2);
    chk("t1_pending", exp_q.size(), 0);

    // Two words back-to-back, good checksum
    drops = 0;
    frame_two(8'h08);
    status("t2", 1'b1, 1'b0, 1'b0, 2);
    chk("t2_ready_drops", drops, 0);
    idle(2);
    chk("t2_pending", exp_q.size(), 0);

    // Same frame, bad checksum
    frame_two(8'h00);
    status("t3", 1'b0, 1'b1, 1'b1, 2);
    idle(2);
    chk("t3_pending", exp_q.size(), 0);

    // Oversized length: 2049 words
    send(8'hA5); send(8'h01); send(8'h08);
    status("t4_len", 1'b0, 1'b1, 1'b1, 0);
    idle(3);
    chk("t4_nowrite", exp_q.size(), 0);
    frame_one();
    status("t4_reload", 1'b1, 1'b0, 1'b0, 1);
    idle(2);
    chk("t4_pending", exp_q.size(), 0);

    // Garbage then an empty frame
    send(8'h00); send(8'hFF); send(8'h13);
    status("t5_garbage", 1'b1, 1'b0, 1'b0, 1);
    send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
    status("t5", 1'b1, 1'b0, 1'b0, 0);
    idle(2);
    chk("t5_pending", exp_q.size(), 0);

    // Reset mid-payload
    send(8'hA5); send(8'h01); send(8'h00);
    send(8'h13); send(8'h00);
    rx_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    status("t6_rst", 1'b0, 1'b0, 1'b1, 0);
    chk("t6_rst_we", 32'(mem_we), 32'h0);
    chk("t6_rst_din", mem_din, 32'h0);
    idle(3);
    chk("t6_nowrite", exp_q.size(), 0);
    frame_two(8'h08);
    status("t6", 1'b1, 1'b0, 1'b0, 2);
    idle(2);
    chk("t6_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
